// File: rtl/mini_cpu_pkg.sv
// Shared widths, opcodes and helpers for the mini RISC-V core.
// Used by the decoder, the register file and the execute/writeback stage.
package mini_cpu_pkg;

    localparam int DATA_W = 4;
    localparam int ADDR_W = 3;
    localparam int CNT_W  = $clog2(DATA_W);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        EX_EMPTY = 2'b00,
        EX_ALU   = 2'b01,
        EX_MUL   = 2'b10
    } ex_state_e;

    // One shift-add step: the multiplicand shifted by the current bit position, or zero.
    function automatic logic [DATA_W-1:0] mul_partial(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input logic [CNT_W-1:0]  cnt
    );
        if (b[cnt]) begin
            mul_partial = a << cnt;
        end else begin
            mul_partial = {DATA_W{1'b0}};
        end
    endfunction

endpackage

// File: rtl/exec_wb_stage_if.sv
// Instruction-in / register-file-write bus between decode, exec_wb_stage and the register file.
// master = decode/regfile side, slave = exec_wb_stage.
interface exec_wb_stage_if;
    import mini_cpu_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_op;
    logic [ADDR_W-1:0] in_rd;
    logic [ADDR_W-1:0] in_rs1;
    logic [ADDR_W-1:0] in_rs2;
    logic [DATA_W-1:0] in_rs1_data;
    logic [DATA_W-1:0] in_rs2_data;
    logic [DATA_W-1:0] in_imm;
    logic              in_use_imm;
    logic              we;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2,
               in_rs1_data, in_rs2_data, in_imm, in_use_imm,
        input  in_ready, we, rd_addr, rd_data
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2,
               in_rs1_data, in_rs2_data, in_imm, in_use_imm,
        output in_ready, we, rd_addr, rd_data
    );

endinterface

// File: rtl/mini_alu.sv
// Single-cycle ALU for the mini core; MUL is iterated in exec_wb_stage and yields zero here.
module mini_alu
    import mini_cpu_pkg::*;
(
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [2:0]        i_op,
    output logic [DATA_W-1:0] o_result
);

    // Opcode decode; every result wraps to DATA_W bits.
    always_comb begin
        o_result = {DATA_W{1'b0}};
        case (i_op)
            OP_ADD:  o_result = i_a + i_b;
            OP_SUB:  o_result = i_a - i_b;
            OP_AND:  o_result = i_a & i_b;
            OP_OR:   o_result = i_a | i_b;
            OP_XOR:  o_result = i_a ^ i_b;
            OP_SLL:  o_result = i_a << i_b[1:0];
            OP_SLT:  o_result = {{(DATA_W-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            default: o_result = {DATA_W{1'b0}};
        endcase
    end

endmodule

// File: rtl/exec_wb_stage.sv
// Execute + writeback stage: one EX slot (ALU or 4-cycle shift-add MUL), a registered
// writeback slot driving the register file, and EX/WB forwarding into accepted operands.
module exec_wb_stage
    import mini_cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    exec_wb_stage_if.slave  bus
);

    ex_state_e         r_state;
    logic [2:0]        r_op;
    logic [ADDR_W-1:0] r_rd;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [DATA_W-1:0] r_rd_data;

    logic [DATA_W-1:0] w_alu_res;
    logic [DATA_W-1:0] w_mul_sum;
    logic [DATA_W-1:0] w_ex_res;
    logic [DATA_W-1:0] w_op_a;
    logic [DATA_W-1:0] w_op_b;
    logic              w_mul_last;
    logic              w_ex_final;
    logic              w_ready;
    logic              w_accept;

    mini_alu u_alu (
        .i_a      (r_a),
        .i_b      (r_b),
        .i_op     (r_op),
        .o_result (w_alu_res)
    );

    assign w_mul_last = (r_state == EX_MUL) && (r_cnt == CNT_W'(DATA_W - 1));
    assign w_mul_sum  = r_acc + mul_partial(r_a, r_b, r_cnt);
    assign w_ex_final = (r_state == EX_ALU) || w_mul_last;
    assign w_ex_res   = (r_state == EX_MUL) ? w_mul_sum : w_alu_res;
    // Ready comes back in the last MUL iteration so the next op enters without a gap.
    assign w_ready    = !rst && !((r_state == EX_MUL) && !w_mul_last);
    assign w_accept   = bus.in_valid && w_ready;

    // Operand A: x0 -> 0, then EX result, then WB slot, then register file data.
    always_comb begin
        w_op_a = bus.in_rs1_data;
        if (bus.in_rs1 == {ADDR_W{1'b0}}) begin
            w_op_a = {DATA_W{1'b0}};
        end else if (w_ex_final && (r_rd == bus.in_rs1)) begin
            w_op_a = w_ex_res;
        end else if (r_we && (r_rd_addr == bus.in_rs1)) begin
            w_op_a = r_rd_data;
        end else begin
            w_op_a = bus.in_rs1_data;
        end
    end

    // Operand B: immediate overrides rs2 entirely; otherwise same forwarding order as A.
    always_comb begin
        w_op_b = bus.in_rs2_data;
        if (bus.in_use_imm) begin
            w_op_b = bus.in_imm;
        end else if (bus.in_rs2 == {ADDR_W{1'b0}}) begin
            w_op_b = {DATA_W{1'b0}};
        end else if (w_ex_final && (r_rd == bus.in_rs2)) begin
            w_op_b = w_ex_res;
        end else if (r_we && (r_rd_addr == bus.in_rs2)) begin
            w_op_b = r_rd_data;
        end else begin
            w_op_b = bus.in_rs2_data;
        end
    end

    // EX state machine, multiply iteration and writeback slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= EX_EMPTY;
            r_op      <= OP_ADD;
            r_rd      <= {ADDR_W{1'b0}};
            r_a       <= {DATA_W{1'b0}};
            r_b       <= {DATA_W{1'b0}};
            r_acc     <= {DATA_W{1'b0}};
            r_cnt     <= {CNT_W{1'b0}};
            r_we      <= 1'b0;
            r_rd_addr <= {ADDR_W{1'b0}};
            r_rd_data <= {DATA_W{1'b0}};
        end else begin
            // Address/data only move on a real write, so they hold while we is low.
            if (w_ex_final && (r_rd != {ADDR_W{1'b0}})) begin
                r_we      <= 1'b1;
                r_rd_addr <= r_rd;
                r_rd_data <= w_ex_res;
            end else begin
                r_we      <= 1'b0;
            end

            case (r_state)
                EX_EMPTY, EX_ALU: begin
                    if (w_accept) begin
                        r_state <= (bus.in_op == OP_MUL) ? EX_MUL : EX_ALU;
                        r_op    <= bus.in_op;
                        r_rd    <= bus.in_rd;
                        r_a     <= w_op_a;
                        r_b     <= w_op_b;
                        r_acc   <= {DATA_W{1'b0}};
                        r_cnt   <= {CNT_W{1'b0}};
                    end else begin
                        r_state <= EX_EMPTY;
                    end
                end
                EX_MUL: begin
                    if (!w_mul_last) begin
                        r_acc <= w_mul_sum;
                        r_cnt <= r_cnt + CNT_W'(1);
                    end else if (w_accept) begin
                        r_state <= (bus.in_op == OP_MUL) ? EX_MUL : EX_ALU;
                        r_op    <= bus.in_op;
                        r_rd    <= bus.in_rd;
                        r_a     <= w_op_a;
                        r_b     <= w_op_b;
                        r_acc   <= {DATA_W{1'b0}};
                        r_cnt   <= {CNT_W{1'b0}};
                    end else begin
                        r_state <= EX_EMPTY;
                    end
                end
                default: begin
                    r_state <= EX_EMPTY;
                end
            endcase
        end
    end

    assign bus.in_ready = w_ready;
    assign bus.we       = r_we;
    assign bus.rd_addr  = r_rd_addr;
    assign bus.rd_data  = r_rd_data;

endmodule

// File: doc/exec_wb_stage.md
Name: exec_wb_stage

Overview:
Execute and writeback stage of the mini RISC-V core. It sits directly downstream of the register file's read ports and upstream of its write port.
- Accepts decoded instructions together with the operand data read asynchronously in the same cycle.
- Performs the ALU operation, including an iterative 4-cycle multiply.
- Drives the register file write port (we / rd_addr / rd_data) from a registered writeback slot.
- Forwards in-flight results so back-to-back dependent instructions see correct operands.

Parameters:
DATA_W, 4, datapath width; must match the register file data width.
ADDR_W, 3, register address width (8 architectural registers, x0 hardwired to zero).

Ports:
clk  input  1  single clock; all state updates on posedge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  instruction offered this cycle.
in_ready  output  1  stage can accept; transfer occurs when in_valid && in_ready.
in_op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SLT, 111 MUL.
in_rd  input  ADDR_W  destination register.
in_rs1  input  ADDR_W  source 1 address (used for forwarding compare).
in_rs2  input  ADDR_W  source 2 address (used for forwarding compare).
in_rs1_data  input  DATA_W  register file read data for rs1 (may be stale).
in_rs2_data  input  DATA_W  register file read data for rs2 (may be stale).
in_imm  input  DATA_W  immediate.
in_use_imm  input  1  1 = operand B is in_imm; 0 = operand B is forwarded rs2.
we  output  1  register file write enable.
rd_addr  output  ADDR_W  register file write address.
rd_data  output  DATA_W  register file write data.

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous, active-high.
- Reset response:
  - Clears the EX slot, WB slot and multiply counter.
  - we=0, rd_addr=0, rd_data=0 from the first edge with rst high.
  - in_ready=0 while rst is high.
  - A multiply in progress at reset is abandoned; its result is never written.
- Pipeline:
  - Accept at cycle N loads the EX register with op, rd, operand A and operand B.
  - The ALU evaluates in N+1. The WB register loads at the end of N+1.
  - we is high in N+2; the register file commits at the end of N+2.
- Writeback outputs: we = wb_valid && (wb_rd != 0). Writes to x0 are suppressed. rd_addr/rd_data are registered and hold their values when we=0.
- Forwarding at accept, per source register, with priority EX > WB > register file:
  - EX hit: EX valid, EX result final this cycle, ex_rd == rs, rs != 0. Use the combinational ALU result.
  - WB hit: we && rd_addr == rs. Use rd_data.
  - Source address 0 always yields 0 regardless of hits.
- Operand B mux: when in_use_imm=1, operand B = in_imm and rs2 forwarding is ignored.
- ALU arithmetic:
  - All results are truncated to DATA_W; carry and borrow are discarded.
  - SUB: A - B mod 16.
  - SLL: A << B[1:0].
  - SLT: 1 if signed(A) < signed(B), else 0.
- MUL:
  - Shift-add, one multiplier bit per cycle: acc += B[cnt] ? (A << cnt) : 0.
  - cnt runs 0..DATA_W-1 over the first DATA_W cycles in EX, and acc starts at 0.
  - in_ready=0 while a MUL is in EX with cnt != DATA_W-1. in_ready returns to 1 in the final iteration cycle, so a new instruction can enter back-to-back.
  - Accept at N gives we in N+DATA_W+1 (N+5 for DATA_W=4).
- EX state machine:
  - States: EMPTY, ALU, MUL.
  - EMPTY or ALU, on accept: go to ALU (non-MUL op) or MUL with cnt=0.
  - ALU, no accept: go to EMPTY.
  - MUL: cnt increments each cycle. At cnt==DATA_W-1, move to WB and go to ALU, MUL or EMPTY depending on the simultaneous accept.
- No bubble: in_valid=0 never inserts a stall; an empty slot simply produces we=0.
- Simultaneous events: an instruction accepted in the same cycle that WB writes the same register receives the forwarded WB value. The register file write and the new read do not conflict.

Decomposition:
- Package mini_cpu_pkg holds:
  - DATA_W and ADDR_W constants.
  - Opcode localparams OP_ADD..OP_MUL.
  - Reused by the decoder and the register file instance.
- One combinational sub-module, mini_alu (a, b, op -> result), covers the single-cycle ops.
- The multiply iteration and FSM remain in exec_wb_stage.

Test Plan:
- After reset, ADD rd=1 rs1=0 imm=5 use_imm=1 accepted at cycle 0 -> cycle 2: we=1, rd_addr=1, rd_data=5. Cycles 0-1: we=0.
- Back-to-back EX forward: ADD x1=x0+3, then next cycle ADD x2=x1+x1 with in_rs1_data=in_rs2_data=0 (stale) -> x1 write 3, then x2 write 6.
- WB forward: ADD x1=x0+7, one idle cycle, ADD x3=x1+imm 1 with in_rs1_data=0 -> x3 write 8.
- MUL with x1=6, x2=3 in regfile, MUL x4=x1*x2 -> in_ready low 3 cycles, we 5 cycles after accept, rd_data=2 (18 mod 16). An ADD queued behind it is accepted in the final MUL cycle and writes one cycle after the MUL.
- Edge ops -> SUB 2-5 gives 0xD; SLT 0xF vs 1 gives 1; SLL 0x3 by 3 gives 0x8; ADD rd=0 gives we=0 throughout.
- Reset mid-MUL: rst high in the second MUL cycle for one cycle -> no we ever asserted for that MUL; in_ready=1 the cycle after rst falls; rd_addr=0 and rd_data=0 after reset.
